// File: rtl/dyt_sram_resp_pkg.sv
// Shared types for the SRAM responder slice.
// Package common_types:
//   word_t       - 32-bit data/address word
//   sram_state_t - responder FSM states (IDLE, RD_WAIT)
//   addr_bad()   - true when a byte address is misaligned or beyond the array
package common_types;

   typedef logic [31:0] word_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } sram_state_t;

   // Misaligned (low two bits set) or past the last word of a depth-word array.
   function automatic logic addr_bad(input word_t addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ((addr >> 2) >= word_t'(depth));
   endfunction

endpackage

// File: rtl/dyt_sram_if.sv
// Bundle of the SRAM request/response signals.
// Ports: clk (input).
// Modports:
//   sram   - the responder side (dyt_sram_resp)
//   master - the requester side
interface dyt_sram_if (input logic clk);
   import common_types::*;

   logic  rst;
   word_t sram_address;
   word_t sram_w_data;
   logic  sram_ren;
   logic  sram_wen;
   word_t sram_r_data;
   logic  sram_r_valid;
   logic  sram_busy;
   logic  sram_err;

   modport sram (
      input  clk, rst, sram_address, sram_w_data, sram_ren, sram_wen,
      output sram_r_data, sram_r_valid, sram_busy, sram_err
   );

   modport master (
      input  clk, sram_r_data, sram_r_valid, sram_busy, sram_err,
      output rst, sram_address, sram_w_data, sram_ren, sram_wen
   );

endinterface

// File: rtl/dyt_sram_array.sv
// Single-port word storage: synchronous write, registered read with read
// enable, no reset on contents or read register (maps onto block RAM).
// Ports:
//   clk   - clock
//   we    - write enable for this edge
//   re    - read enable; rdata loads mem[addr] and holds otherwise
//   addr  - word index
//   wdata - write data
//   rdata - registered read data
module dyt_sram_array
   import common_types::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  word_t                          wdata,
   output word_t                          rdata
);

   word_t mem [DEPTH_WORDS];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read port; holds its value while re is low.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dyt_sram_resp.sv
// SRAM responder: writes complete in one cycle, reads return after RD_LAT
// cycles with a one-cycle sram_r_valid pulse. Requests are ignored while a
// read is in flight (sram_busy).
// Optional feature macro: DYT_SRAM_ERR_EN -- flags misaligned or out-of-range
// requests on sram_err, drops such writes and returns 0 for such reads.
// Without it the address wraps modulo DEPTH_WORDS and sram_err stays 0.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   sram_address               - byte address (bits [1:0] ignored for indexing)
//   sram_w_data                - write data
//   sram_ren, sram_wen         - read/write request levels (write wins)
//   sram_r_data, sram_r_valid  - read data and its one-cycle valid pulse
//   sram_busy                  - read in flight
//   sram_err                   - one-cycle error pulse
module dyt_sram_resp
   import common_types::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LAT      = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  word_t sram_address,
   input  word_t sram_w_data,
   input  logic  sram_ren,
   input  logic  sram_wen,
   output word_t sram_r_data,
   output logic  sram_r_valid,
   output logic  sram_busy,
   output logic  sram_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DYT_SRAM_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   sram_state_t   state;
   logic [2:0]    cnt;
   logic          busy;
   logic          r_valid;
   word_t         r_data;
   logic          err;
   logic          rd_bad;
   logic          req_bad;
   logic          write_go;
   logic          read_go;
   logic [AW-1:0] idx;
   word_t         arr_rdata;

   assign idx      = sram_address[AW+1:2];
   assign req_bad  = ERR_EN & addr_bad(sram_address, DEPTH_WORDS);
   // Reset blocks both ports; a bad write never reaches the array.
   assign write_go = !rst && (state == IDLE) && sram_wen && !req_bad;
   // The array read is launched at acceptance, so data is ready well before
   // the counter expires and cannot be disturbed (writes are ignored while busy).
   assign read_go  = !rst && (state == IDLE) && sram_ren && !sram_wen;

   dyt_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (write_go),
      .re    (read_go),
      .addr  (idx),
      .wdata (sram_w_data),
      .rdata (arr_rdata)
   );

   // Request FSM, latency counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         busy    <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= 32'h0000_0000;
         err     <= 1'b0;
         rd_bad  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (sram_wen) begin
                  err <= req_bad;
               end else if (sram_ren) begin
                  state  <= RD_WAIT;
                  busy   <= 1'b1;
                  cnt    <= 3'(RD_LAT - 1);
                  rd_bad <= req_bad;
                  err    <= req_bad;
               end else begin
                  state <= IDLE;
               end
            end
            RD_WAIT: begin
               if (cnt == 3'd0) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  r_valid <= 1'b1;
                  r_data  <= rd_bad ? 32'h0000_0000 : arr_rdata;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sram_r_data  = r_data;
   assign sram_r_valid = r_valid;
   assign sram_busy    = busy;
   assign sram_err     = err;

endmodule

// File: tb/tb_dyt_sram_resp.sv
// Bench for dyt_sram_resp: two instances (RD_LAT=2 and RD_LAT=1) share one
// stimulus stream; a transaction-level model per instance predicts outputs
// that are compared every cycle, plus literal checks on directed scenarios.
module tb_dyt_sram_resp;

   localparam int DEPTH = 1024;
`ifdef DYT_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, ren, wen;
   logic [31:0] addr, wdata;
   logic [31:0] rd0, rd1;
   logic        rv0, rv1, bz0, bz1, er0, er1;

   always #5 clk = ~clk;

   dyt_sram_resp #(.DEPTH_WORDS(DEPTH), .RD_LAT(2)) dut0 (
      .clk(clk), .rst(rst), .sram_address(addr), .sram_w_data(wdata),
      .sram_ren(ren), .sram_wen(wen), .sram_r_data(rd0),
      .sram_r_valid(rv0), .sram_busy(bz0), .sram_err(er0));

   dyt_sram_resp #(.DEPTH_WORDS(DEPTH), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .sram_address(addr), .sram_w_data(wdata),
      .sram_ren(ren), .sram_wen(wen), .sram_r_data(rd1),
      .sram_r_valid(rv1), .sram_busy(bz1), .sram_err(er1));

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   // Model state per instance.
   int          lat [2] = '{2, 1};
   logic [31:0] mmem [2][DEPTH];
   bit          mknown [2][DEPTH];
   bit          pending [2];
   int          rem [2];
   logic [31:0] pd [2];
   bit          pk [2];
   bit          ev [2], eb [2], ee [2], edk [2];
   logic [31:0] ed [2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
   endtask

   // One clock edge of instance i, from the inputs seen at that edge.
   task automatic model_edge(input int i);
      int unsigned widx;
      bit bad;
      widx = (addr >> 2) % DEPTH;
      bad  = ERR_EN && ((addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH)));
      if (rst) begin
         pending[i] = 1'b0; ev[i] = 1'b0; ee[i] = 1'b0;
         ed[i] = 32'h0; edk[i] = 1'b1;
      end else begin
         ev[i] = 1'b0; ee[i] = 1'b0;
         if (pending[i]) begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) begin
               ev[i] = 1'b1; ed[i] = pd[i]; edk[i] = pk[i]; pending[i] = 1'b0;
            end
         end else if (wen) begin
            ee[i] = bad;
            if (!bad) begin
               mmem[i][widx] = wdata; mknown[i][widx] = 1'b1;
            end
         end else if (ren) begin
            ee[i] = bad;
            pending[i] = 1'b1; rem[i] = lat[i];
            pd[i] = bad ? 32'h0 : mmem[i][widx];
            pk[i] = bad ? 1'b1 : mknown[i][widx];
         end
      end
      eb[i] = pending[i];
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic cmp_inst(input int i, input logic v, input logic b, input logic e, input logic [31:0] d);
      chk($sformatf("valid%0d", i), {31'h0, v}, {31'h0, ev[i]});
      chk($sformatf("busy%0d", i),  {31'h0, b}, {31'h0, eb[i]});
      chk($sformatf("err%0d", i),   {31'h0, e}, {31'h0, ee[i]});
      if (edk[i]) chk($sformatf("rdata%0d", i), d, ed[i]);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, rv0, bz0, er0, rd0);
         cmp_inst(1, rv1, bz1, er1, rd1);
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      wen = 1'b1; ren = 1'b0; addr = a; wdata = d;
      step();
      wen = 1'b0;
   endtask

   initial begin
      logic [31:0] vals [3];
      vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_busy",  {31'h0, bz0}, 32'h0);
      chk("reset_valid", {31'h0, rv0}, 32'h0);
      chk("reset_rdata", rd0, 32'h0);

      // Write then read with RD_LAT=2.
      do_write(32'h10, 32'hDEAD_BEEF);
      ren = 1'b1; addr = 32'h10;
      step();
      ren = 1'b0;
      chk("rd_busy_c0", {31'h0, bz0}, 32'h1);
      chk("rd_valid_c0", {31'h0, rv0}, 32'h0);
      step();
      chk("rd_busy_c1", {31'h0, bz0}, 32'h1);
      step();
      chk("rd_valid_c2", {31'h0, rv0}, 32'h1);
      chk("rd_data_c2", rd0, 32'hDEAD_BEEF);
      chk("rd_busy_c2", {31'h0, bz0}, 32'h0);

      // Read and write together: write wins.
      ren = 1'b1; wen = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
      step();
      ren = 1'b0; wen = 1'b0;
      chk("rw_nobusy", {31'h0, bz0}, 32'h0);
      ren = 1'b1;
      step();
      ren = 1'b0;
      step(); step();
      chk("rw_readback", rd0, 32'h1234_5678);

      // Write while busy is ignored.
      ren = 1'b1; addr = 32'h10;
      step();
      ren = 1'b0; wen = 1'b1; wdata = 32'h0;
      step();
      wen = 1'b0;
      step();
      ren = 1'b1;
      step();
      ren = 1'b0;
      step(); step();
      chk("busy_wr_ign0", rd0, 32'hDEAD_BEEF);
      chk("busy_wr_ign1", rd1, 32'hDEAD_BEEF);

      // Reset one cycle after read acceptance.
      ren = 1'b1; addr = 32'h20;
      step();
      ren = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", {31'h0, bz0}, 32'h0);
      chk("abort_valid", {31'h0, rv0}, 32'h0);
      chk("abort_rdata", rd0, 32'h0);
      step();
      chk("abort_nopulse", {31'h0, rv0}, 32'h0);
      ren = 1'b1;
      step();
      ren = 1'b0;
      step(); step();
      chk("abort_kept", rd0, 32'h1234_5678);

      // Out-of-range address.
      do_write(32'h0, 32'hA5A5_0001);
      ren = 1'b1; addr = 32'h1000;
      step();
      ren = 1'b0;
      chk("oor_err", {31'h0, er0}, {31'h0, ERR_EN});
      step(); step();
      chk("oor_rdata", rd0, ERR_EN ? 32'h0 : 32'hA5A5_0001);

      // Back-to-back reads with RD_LAT=1.
      for (int k = 0; k < 3; k++) do_write(32'(4 * k), vals[k]);
      for (int k = 0; k < 3; k++) begin
         ren = 1'b1; addr = 32'(4 * k);
         step();
         ren = 1'b0;
         chk($sformatf("b2b_novalid%0d", k), {31'h0, rv1}, 32'h0);
         step();
         chk($sformatf("b2b_valid%0d", k), {31'h0, rv1}, 32'h1);
         chk($sformatf("b2b_data%0d", k), rd1, vals[k]);
      end

      // Randomized traffic over a small word set with aliasing high bits.
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         ren   = 1'($urandom_range(0, 1));
         wen   = ($urandom_range(0, 3) == 0);
         addr  = 32'($urandom_range(0, 15)) << 2;
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h1000 * 32'($urandom_range(1, 3)));
         if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
         wdata = $urandom;
         step();
      end
      rst = 1'b0; ren = 1'b0; wen = 1'b0;
      for (int n = 0; n < 10; n++) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dyt_sram_resp.md
DYT_SRAM_RESP -- requirements
Module: dyt_sram_resp

Interface
REQ-001 The block SHALL have the parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage (power of two, at least 2).
REQ-002 The block SHALL have the parameter RD_LAT, default 2, meaning the number of cycles from read acceptance to the sram_r_valid pulse (1..7).
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; one clock, all logic on the rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have the port sram_address, input, word_t (32 bits), the byte address of the request.
REQ-006 The block SHALL have the port sram_w_data, input, word_t, the write data.
REQ-007 The block SHALL have the ports sram_ren and sram_wen, input, 1 bit each, the read and write requests (level, sampled every cycle).
REQ-008 The block SHALL have the port sram_r_data, output, word_t, the read data.
REQ-009 The block SHALL have the port sram_r_valid, output, 1 bit, a one-cycle pulse marking valid sram_r_data.
REQ-010 The block SHALL have the port sram_busy, output, 1 bit, meaning a read is in flight and new requests are not accepted.
REQ-011 The block SHALL have the port sram_err, output, 1 bit, a one-cycle error pulse (present only with DYT_SRAM_ERR_EN; tied 0 otherwise).

Function
REQ-012 The word index SHALL be sram_address[log2(DEPTH_WORDS)+1:2]; bits [1:0] are ignored; no byte enables.
REQ-013 The FSM SHALL have the states IDLE and RD_WAIT; reset enters IDLE.
REQ-014 In IDLE with sram_wen=1, sram_w_data SHALL be written to the indexed word at that clock edge; the state stays IDLE; no busy, no valid.
REQ-015 In IDLE with sram_ren=1 and sram_wen=0, the address SHALL be latched, the block SHALL move to RD_WAIT, and a latency counter SHALL be loaded with RD_LAT-1.
REQ-016 sram_busy SHALL be 1 exactly while in RD_WAIT and 0 in IDLE (it is a registered state decode).
REQ-017 In RD_WAIT, when the counter is 0, the block SHALL drive sram_r_valid=1 for that single cycle, update sram_r_data, and return to IDLE; otherwise it SHALL decrement.
REQ-018 The cycle count SHALL be: a read accepted at edge N gives sram_r_valid high during cycle N+RD_LAT.
REQ-019 sram_r_data SHALL hold its last value between reads; it SHALL change only with an sram_r_valid pulse.
REQ-020 When sram_ren=1 and sram_wen=1 in IDLE, the write SHALL win; no read is started and no error is raised.
REQ-021 sram_ren and sram_wen SHALL be ignored while busy; the requester holds or re-issues after busy falls.
REQ-022 A read issued the cycle after a write to the same word SHALL return the newly written data.
REQ-023 Storage contents SHALL not be initialised; a read of a never-written word returns an undefined value.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, sram_busy=0, sram_r_valid=0, sram_r_data=0, sram_err=0.
REQ-025 Reset mid-read SHALL abort the read with no sram_r_valid pulse; storage contents SHALL be preserved.
REQ-026 A write request during reset SHALL be ignored.

Configuration
REQ-027 With DYT_SRAM_ERR_EN defined, an accepted request with sram_address >= 4*DEPTH_WORDS or sram_address[1:0]!=0 SHALL pulse sram_err one cycle after acceptance.
REQ-028 With DYT_SRAM_ERR_EN defined, an erroneous write SHALL be dropped and an erroneous read SHALL still complete with sram_r_data=0.
REQ-029 Without DYT_SRAM_ERR_EN, sram_err SHALL be 0 and the address SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-030 The package common_types SHALL hold word_t and the new enum sram_state_t {IDLE, RD_WAIT}.
REQ-031 Storage SHALL be the sub-module dyt_sram_array (synchronous-write, registered-read array inferable as Xilinx BRAM); the FSM, counter and error logic stay in dyt_sram_resp.
REQ-032 The block SHALL connect to the sram modport of dyt_sram_if; sram_r_valid, sram_busy and sram_err SHALL be added to that interface and its modports.

Verification
REQ-033 The bench SHALL cover: write 0xDEADBEEF to 0x10, then read 0x10 with RD_LAT=2 -> sram_busy for 2 cycles, sram_r_valid at N+2, sram_r_data=0xDEADBEEF.
REQ-034 The bench SHALL cover: ren and wen together to 0x20 with data 0x12345678 -> write only, no busy; a later read of 0x20 returns 0x12345678.
REQ-035 The bench SHALL cover: read 0x10 then a write to 0x10 of 0x0 while busy -> the write is ignored and a later read still returns 0xDEADBEEF.
REQ-036 The bench SHALL cover: rst asserted 1 cycle after read acceptance -> no sram_r_valid, sram_busy=0 next cycle, sram_r_data=0.
REQ-037 The bench SHALL cover: with DYT_SRAM_ERR_EN and DEPTH_WORDS=1024, read 0x1000 -> sram_err pulse, sram_r_data=0; without it, 0x1000 aliases 0x0.
REQ-038 The bench SHALL cover: back-to-back reads of 0x0, 0x4 and 0x8 with RD_LAT=1 -> valid every 2 cycles with the data in order.
